self_test_scheduler: RTL

Sequences the TPM algorithm self-tests over the shared crypto test engine on behalf of the management module. It drives TPM2_SelfTest (full) and TPM2_IncrementalSelfTest passes one test at a time through a request/done handshake. It tracks which tests have been executed and maintains the `tests_run`, `tests_passed` and `untested` counts that the management FSM consumes. It sits between the management module (command side) and the crypto engine (test execution side).

---
 rtl/tpm_mgmt_pkg.sv | 24 ++
 rtl/self_test_scheduler_if.sv | 28 ++
 rtl/selftest_timer.sv | 40 ++++
 rtl/self_test_scheduler.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/tpm_mgmt_pkg.sv
// Shared definitions for the TPM management slice.
//   - sched_state_e   : self-test scheduler FSM encoding
//   - NumTestsDefault : default number of algorithm self-tests
//   - TPMI_YES/TPMI_NO: TPM boolean encodings used for the full/incremental flag
//   - sat_inc16       : 16-bit increment that sticks at 16'hFFFF
package tpm_mgmt_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StWait,
    StFinish
  } sched_state_e;

  localparam int unsigned NumTestsDefault = 40;

  localparam logic TPMI_YES = 1'b1;
  localparam logic TPMI_NO  = 1'b0;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/self_test_scheduler_if.sv
// Request/done handshake between the self-test scheduler and the crypto test engine.
//   test_req  : scheduler -> engine, request a test run
//   test_id   : scheduler -> engine, id under test, stable while test_req is high
//   test_done : engine -> scheduler, single-cycle completion pulse
//   test_pass : engine -> scheduler, result, valid with test_done
// master = scheduler side, slave = engine side.
interface self_test_scheduler_if;

  logic       test_req;
  logic [5:0] test_id;
  logic       test_done;
  logic       test_pass;

  modport master (
    output test_req,
    output test_id,
    input  test_done,
    input  test_pass
  );

  modport slave (
    input  test_req,
    input  test_id,
    output test_done,
    output test_pass
  );

endinterface

// File: rtl/selftest_timer.sv
// Watchdog for one outstanding self-test request.
//   clock, reset_n : clock and asynchronous active-low reset
//   clear          : zero the count (takes priority over enable)
//   enable         : count one cycle of waiting
//   expire         : high during the TIMEOUT-th enabled cycle after a clear
module selftest_timer #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  // The count reads k during the (k+1)-th waiting cycle, so TIMEOUT-1 marks the last one.
  localparam logic [15:0] Limit = 16'(TIMEOUT - 1);

  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = enable && (count_q == Limit);

endmodule

// File: rtl/self_test_scheduler.sv
// Sequences TPM algorithm self-tests (full or incremental passes) over the shared crypto
// test engine, one test at a time, and keeps the run/pass/untested bookkeeping that the
// management FSM consumes.
//   clock, reset_n : clock and asynchronous active-low reset
//   start          : single-cycle pass start, honoured only when idle and not failed
//   full_test      : sampled with start; 1 = all ids, 0 = only ids never executed
//   eng            : request/done handshake towards the crypto test engine
//   busy           : FSM is not idle
//   done           : single-cycle pulse as a pass ends
//   failed         : sticky failure flag, cleared only by reset
//   tests_run      : tests executed (saturating)
//   tests_passed   : tests passed (saturating)
//   untested       : ids not executed since reset or the last full-pass start
module self_test_scheduler
  import tpm_mgmt_pkg::*;
#(
  parameter int unsigned NUM_TESTS = NumTestsDefault,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  full_test,
  self_test_scheduler_if.master eng,
  output logic                  busy,
  output logic                  done,
  output logic                  failed,
  output logic [15:0]           tests_run,
  output logic [15:0]           tests_passed,
  output logic [15:0]           untested
);

  localparam logic [5:0]  LastIdx    = 6'(NUM_TESTS - 1);
  localparam logic [15:0] NumTests16 = 16'(NUM_TESTS);

  sched_state_e           state_q, state_d;
  logic [5:0]             idx_q, idx_d;
  logic                   full_q, full_d;
  logic                   req_q, req_d;
  logic [5:0]             id_q, id_d;
  logic                   failed_q, failed_d;
  logic [15:0]            run_q, run_d;
  logic [15:0]            passed_q, passed_d;
  logic [15:0]            untested_q, untested_d;
  logic [NUM_TESTS-1:0]   mask_q, mask_d;

  logic timer_clear;
  logic timer_enable;
  logic timer_expire;

  selftest_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expire (timer_expire)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    full_d       = full_q;
    req_d        = req_q;
    id_d         = id_q;
    failed_d     = failed_q;
    run_d        = run_q;
    passed_d     = passed_q;
    untested_d   = untested_q;
    mask_d       = mask_q;
    timer_clear  = 1'b0;
    timer_enable = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && !failed_q) begin
          full_d  = full_test ? TPMI_YES : TPMI_NO;
          idx_d   = '0;
          state_d = StScan;
          // A full pass restarts the bookkeeping from scratch.
          if (full_test) begin
            mask_d     = '0;
            run_d      = '0;
            passed_d   = '0;
            untested_d = NumTests16;
          end
        end
      end

      StScan: begin
        if ((full_q == TPMI_YES) || !mask_q[idx_q]) begin
          id_d        = idx_q;
          req_d       = 1'b1;
          timer_clear = 1'b1;
          state_d     = StWait;
        end else if (idx_q == LastIdx) begin
          state_d = StFinish;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end

      StWait: begin
        timer_enable = 1'b1;
        // Completion is checked first so a done landing on the expiry cycle still counts.
        if (eng.test_done) begin
          req_d = 1'b0;
          run_d = sat_inc16(run_q);
          if (!mask_q[idx_q]) begin
            mask_d[idx_q] = 1'b1;
            untested_d    = untested_q - 16'd1;
          end
          if (eng.test_pass) begin
            passed_d = sat_inc16(passed_q);
            if (idx_q == LastIdx) begin
              state_d = StFinish;
            end else begin
              idx_d   = idx_q + 6'd1;
              state_d = StScan;
            end
          end else begin
            failed_d = 1'b1;
            state_d  = StFinish;
          end
        end else if (timer_expire) begin
          // The engine never answered: the id stays untested but the attempt is counted.
          req_d    = 1'b0;
          failed_d = 1'b1;
          run_d    = sat_inc16(run_q);
          state_d  = StFinish;
        end
      end

      StFinish: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      full_q     <= TPMI_NO;
      req_q      <= 1'b0;
      id_q       <= '0;
      failed_q   <= 1'b0;
      run_q      <= '0;
      passed_q   <= '0;
      untested_q <= NumTests16;
      mask_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      full_q     <= full_d;
      req_q      <= req_d;
      id_q       <= id_d;
      failed_q   <= failed_d;
      run_q      <= run_d;
      passed_q   <= passed_d;
      untested_q <= untested_d;
      mask_q     <= mask_d;
    end
  end

  assign eng.test_req = req_q;
  assign eng.test_id  = id_q;

  // Decodes of the state register only; nothing here sees an input combinationally.
  assign busy         = (state_q != StIdle);
  assign done         = (state_q == StFinish);
  assign failed       = failed_q;
  assign tests_run    = run_q;
  assign tests_passed = passed_q;
  assign untested     = untested_q;

  passed_le_run_a : assert property (@(posedge clock) disable iff (!reset_n)
    passed_q <= run_q);

endmodule
